// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - N-input registered mux with manual select and round-robin scan
module mux_scan_nx1 #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int SW      = $clog2(N),
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SW-1:0]        sel_in,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [N*W-1:0]       din,
    output logic [W-1:0]         dout,
    output logic [SW-1:0]        sel_out,
    output logic                 valid,
    output logic                 wrap
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MANUAL = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;

    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    logic [1:0]         state;
    logic [SW-1:0]      ch;
    logic [DWELL_W-1:0] cnt;

    logic [W-1:0] man_data;
    logic [W-1:0] scan_data;
    logic         man_ok;
    logic         wrap_now;

    // Decode by comparison so out-of-range selects never index past din
    always_comb begin
        man_data  = '0;
        scan_data = '0;
        man_ok    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel_in == SW'(k)) begin
                man_data = din[k*W +: W];
                man_ok   = 1'b1;
            end
            if (ch == SW'(k)) begin
                scan_data = din[k*W +: W];
            end
        end
    end

    // valid is low on the SCAN entry cycle, which suppresses a wrap on entry
    assign wrap_now = (ch == '0) && (sel_out == LAST_CH) && valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ch      <= '0;
            cnt     <= '0;
            dout    <= '0;
            sel_out <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else if (!en) begin
            state <= S_IDLE;
            ch    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            state   <= S_MANUAL;
            ch      <= '0;
            cnt     <= '0;
            dout    <= man_ok ? man_data : '0;
            sel_out <= sel_in;
            valid   <= man_ok;
            wrap    <= 1'b0;
        end else if (state != S_SCAN) begin
            state <= S_SCAN;
            ch    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            dout    <= scan_data;
            sel_out <= ch;
            valid   <= 1'b1;
            wrap    <= wrap_now;
            if (cnt >= dwell) begin
                cnt <= '0;
                ch  <= (ch == LAST_CH) ? '0 : ch + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
